// File: rtl/dcache_req_arbiter_pkg.sv
// Shared widths, opcode encodings and the dcache request payload
// used by the arbiter, its tag tracker and the dcache-side interface.
package dcache_req_arbiter_pkg;
    localparam int XLEN             = 64;
    localparam int VIRTUAL_ADDR_LEN = 32;
    localparam int ROB_INDEX_WIDTH  = 2;
    localparam int ROB_DEPTH        = 1 << ROB_INDEX_WIDTH;

    localparam logic DCACHE_OP_LOAD  = 1'b0;
    localparam logic DCACHE_OP_STORE = 1'b1;

    typedef struct packed {
        logic                        opcode;
        logic [VIRTUAL_ADDR_LEN-1:0] addr;
        logic [2:0]                  typ;
        logic [XLEN-1:0]             data;
        logic [ROB_INDEX_WIDTH-1:0]  tag;
    } dc_req_t;
endpackage

// File: rtl/dcache_req_arbiter_if.sv
// Dcache request/response port; master is the arbiter, slave is the dcache.
// Signal suffixes are relative to the arbiter.
interface dcache_req_arbiter_if;
    import dcache_req_arbiter_pkg::*;

    logic                        dc_req_valid_o;
    logic                        dc_req_ready_i;
    logic                        dc_opcode_o;
    logic [VIRTUAL_ADDR_LEN-1:0] dc_req_addr_o;
    logic [2:0]                  dc_type_o;
    logic [XLEN-1:0]             dc_st_data_o;
    logic [ROB_INDEX_WIDTH-1:0]  dc_rob_index_o;
    logic                        dc_resp_valid_i;
    logic                        dc_resp_ready_o;
    logic [XLEN-1:0]             dc_ld_data_i;
    logic [ROB_INDEX_WIDTH-1:0]  dc_rob_index_i;

    modport master (
        output dc_req_valid_o, dc_opcode_o, dc_req_addr_o, dc_type_o,
               dc_st_data_o, dc_rob_index_o, dc_resp_ready_o,
        input  dc_req_ready_i, dc_resp_valid_i, dc_ld_data_i, dc_rob_index_i
    );

    modport slave (
        input  dc_req_valid_o, dc_opcode_o, dc_req_addr_o, dc_type_o,
               dc_st_data_o, dc_rob_index_o, dc_resp_ready_o,
        output dc_req_ready_i, dc_resp_valid_i, dc_ld_data_i, dc_rob_index_i
    );
endinterface

// File: rtl/dcache_req_arbiter_tag_tracker.sv
// Per-tag pending/killed bitmaps for outstanding loads. A flush marks every
// pending tag killed; a response handshake clears both bits for its tag.
module dcache_tag_tracker
    import dcache_req_arbiter_pkg::*;
(
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       flush_i,
    input  logic                       set_i,
    input  logic [ROB_INDEX_WIDTH-1:0] set_idx_i,
    input  logic                       clr_i,
    input  logic [ROB_INDEX_WIDTH-1:0] clr_idx_i,
    output logic [ROB_DEPTH-1:0]       pending_o,
    output logic [ROB_DEPTH-1:0]       killed_o
);
    logic [ROB_DEPTH-1:0] pending_q, pending_d;
    logic [ROB_DEPTH-1:0] killed_q, killed_d;
    logic [ROB_DEPTH-1:0] set_mask, clr_mask;

    // Clear is applied last so a same-cycle response beats the flush.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_i) set_mask[set_idx_i] = 1'b1;
        if (clr_i) clr_mask[clr_idx_i] = 1'b1;
        pending_d = (pending_q | set_mask) & ~clr_mask;
        killed_d  = (flush_i ? (pending_q | set_mask) : killed_q) & ~clr_mask;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending_q <= '0;
            killed_q  <= '0;
        end else begin
            pending_q <= pending_d;
            killed_q  <= killed_d;
        end
    end

    // A response for a tag with no load in flight is a protocol error.
    always_ff @(posedge clk) begin
        if (rstn && clr_i) assert (pending_q[clr_idx_i]);
    end

    assign pending_o = pending_q;
    assign killed_o  = killed_q;
endmodule

// File: rtl/dcache_req_arbiter.sv
// Arbitrates the LSU load pipe and store-commit pipe onto one registered
// dcache request slot, and routes load responses back, dropping squashed ones.
module dcache_req_arbiter
    import dcache_req_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT     = 4,
    parameter int STARVE_CNT_WIDTH = 3
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        flush_i,
    input  logic                        ld_req_valid_i,
    output logic                        ld_req_ready_o,
    input  logic [VIRTUAL_ADDR_LEN-1:0] ld_req_addr_i,
    input  logic [2:0]                  ld_req_type_i,
    input  logic [ROB_INDEX_WIDTH-1:0]  ld_req_rob_index_i,
    input  logic                        st_req_valid_i,
    output logic                        st_req_ready_o,
    input  logic [VIRTUAL_ADDR_LEN-1:0] st_req_addr_i,
    input  logic [2:0]                  st_req_type_i,
    input  logic [XLEN-1:0]             st_req_data_i,
    output logic                        ld_resp_valid_o,
    input  logic                        ld_resp_ready_i,
    output logic [XLEN-1:0]             ld_resp_data_o,
    output logic [ROB_INDEX_WIDTH-1:0]  ld_resp_rob_index_o,
    output logic [ROB_DEPTH-1:0]        outstanding_o,
    dcache_req_arbiter_if.master        dc
);
    dc_req_t                     slot_q, slot_d;
    logic                        slot_valid_q, slot_valid_d;
    logic [STARVE_CNT_WIDTH-1:0] starve_cnt_q, starve_cnt_d;
    logic [ROB_DEPTH-1:0]        pending, killed;
    logic slot_free, ld_ok, st_ok, st_urgent, ld_gnt, st_gnt, kill, resp_hs;

    assign slot_free = ~slot_valid_q | dc.dc_req_ready_i;
    // Eligibility looks at registered pending, so a tag freed this cycle is reusable next cycle.
    assign ld_ok     = ld_req_valid_i & ~pending[ld_req_rob_index_i] & ~flush_i;
    assign st_ok     = st_req_valid_i;
    assign st_urgent = st_ok & (starve_cnt_q >= STARVE_CNT_WIDTH'(STARVE_LIMIT));
    assign st_gnt    = slot_free & st_ok & (st_urgent | ~ld_ok);
    assign ld_gnt    = slot_free & ld_ok & ~st_gnt;

    assign ld_req_ready_o = ld_gnt;
    assign st_req_ready_o = st_gnt;

    always_comb begin
        slot_d       = slot_q;
        slot_valid_d = slot_valid_q;
        if (slot_free) begin
            slot_valid_d = ld_gnt | st_gnt;
            if (ld_gnt) begin
                slot_d = '{opcode: DCACHE_OP_LOAD, addr: ld_req_addr_i, typ: ld_req_type_i,
                           data: '0, tag: ld_req_rob_index_i};
            end else if (st_gnt) begin
                slot_d = '{opcode: DCACHE_OP_STORE, addr: st_req_addr_i, typ: st_req_type_i,
                           data: st_req_data_i, tag: '0};
            end
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (st_gnt || !st_req_valid_i)
            starve_cnt_d = '0;
        else if (starve_cnt_q != '1)
            starve_cnt_d = starve_cnt_q + STARVE_CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            slot_q       <= '0;
            slot_valid_q <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            slot_q       <= slot_d;
            slot_valid_q <= slot_valid_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign dc.dc_req_valid_o = slot_valid_q;
    assign dc.dc_opcode_o    = slot_q.opcode;
    assign dc.dc_req_addr_o  = slot_q.addr;
    assign dc.dc_type_o      = slot_q.typ;
    assign dc.dc_st_data_o   = slot_q.data;
    assign dc.dc_rob_index_o = slot_q.tag;

    // Squashed responses are consumed here and never reach the load pipe.
    assign kill                = killed[dc.dc_rob_index_i] | flush_i;
    assign ld_resp_valid_o     = dc.dc_resp_valid_i & ~kill;
    assign ld_resp_data_o      = dc.dc_ld_data_i;
    assign ld_resp_rob_index_o = dc.dc_rob_index_i;
    assign dc.dc_resp_ready_o  = kill | ld_resp_ready_i;
    assign resp_hs             = dc.dc_resp_valid_i & dc.dc_resp_ready_o;

    dcache_tag_tracker u_tracker (
        .clk       (clk),
        .rstn      (rstn),
        .flush_i   (flush_i),
        .set_i     (ld_gnt),
        .set_idx_i (ld_req_rob_index_i),
        .clr_i     (resp_hs),
        .clr_idx_i (dc.dc_rob_index_i),
        .pending_o (pending),
        .killed_o  (killed)
    );

    assign outstanding_o = pending;
endmodule
